// File: rtl/mp_regfile_sb_pkg.sv
// Shared definitions for the RV32 integer register file and its scoreboard.
package rf_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

  // Architectural register indices with special meaning to the core.
  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;
  localparam int REG_SP   = 2;

  typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

endpackage : rf_pkg

// File: rtl/mp_regfile_sb_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback
// releases it, flush squashes every pending producer at once.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_WR     = 2,
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_WR-1:0]                   we,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   wa,
  input  logic [NUM_WR-1:0]                   alloc_en,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   alloc_addr,
  input  logic                                flush,
  output logic [NUM_REGS-1:0]                 busy_vec
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // True when any enabled port in the group targets register r.
  function automatic logic port_hits(
    input logic [NUM_WR-1:0]                 en,
    input logic [NUM_WR-1:0][ADDR_WIDTH-1:0] addr,
    input int                                r
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (en[k] && (addr[k] == ADDR_WIDTH'(r))) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    if (gi == REG_ZERO) begin : g_zero
      // x0 never has a pending producer.
      assign busy_next[gi] = 1'b0;
    end else begin : g_reg
      logic alloc_hit;
      logic clear_hit;
      assign alloc_hit = port_hits(alloc_en, alloc_addr, gi);
      assign clear_hit = port_hits(we, wa, gi);
      // Flush beats everything; a fresh allocation beats a same-cycle writeback
      // because the write belongs to the older producer.
      assign busy_next[gi] = flush     ? 1'b0 :
                             alloc_hit ? 1'b1 :
                             clear_hit ? 1'b0 :
                                         busy_reg[gi];
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

endmodule : rf_scoreboard

// File: rtl/mp_regfile_sb.sv
// Multi-port RV32 integer register file with same-cycle write->read bypass
// and an issue/writeback busy scoreboard for the dual-issue core.
module mp_regfile_sb
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 4,
  parameter int BYPASS     = 1,
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   ra,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd,
  output logic [NUM_RD-1:0]                   rd_busy,
  input  logic [NUM_WR-1:0]                   we,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   wa,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wd,
  input  logic [NUM_WR-1:0]                   alloc_en,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   alloc_addr,
  input  logic                                flush,
  output logic [DATA_WIDTH-1:0]               a0,
  output logic [NUM_REGS-1:0]                 busy_vec
);

  // Flat view of the architectural state, indexed by register number.
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Storage: one register per architectural index, x0 hardwired to zero.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == REG_ZERO) begin : g_zero
      assign reg_view[gi] = '0;
    end else begin : g_store
      logic [DATA_WIDTH-1:0] q_reg;
      logic [DATA_WIDTH-1:0] q_next;

      // Select the youngest enabled writer to this register, else hold.
      always_comb begin
        q_next = q_reg;
        for (int j = 0; j < NUM_WR; j++) begin
          if (we[j] && (wa[j] == ADDR_WIDTH'(gi))) begin
            q_next = wd[j];
          end
        end
      end

      // Register storage; reset clears any in-flight state.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else begin
          q_reg <= q_next;
        end
      end

      assign reg_view[gi] = q_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .wa         (wa),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  // ---------------------------------------------------------------------------
  // Read ports: array lookup, optional same-cycle bypass, x0 forced to zero.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  byp_hit;
    logic                  is_zero;

    assign is_zero = (ra[gi] == ADDR_WIDTH'(REG_ZERO));

    // Later ports override earlier ones so the youngest write is forwarded.
    always_comb begin
      rd_val  = reg_view[ra[gi]];
      byp_hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if ((BYPASS != 0) && we[j] && (wa[j] == ra[gi]) && !is_zero) begin
          rd_val  = wd[j];
          byp_hit = 1'b1;
        end
      end
      if (is_zero) begin
        rd_val = '0;
      end
    end

    assign rd[gi] = rd_val;
    // A forwarded value is already usable, so it never reports busy.
    assign rd_busy[gi] = busy_vec[ra[gi]] & ~byp_hit & ~is_zero;
  end

  // a0 reflects committed state only, never the bypass path.
  assign a0 = reg_view[REG_A0];

endmodule : mp_regfile_sb
